// File: rtl/spi_master_device.sv
// SPI master: issues PRE_PULSES load clocks with CSbar high, then a 17-pulse frame
// (dummy bit + 16 data bits, MSB first) while shifting in a 16-bit word from MISO.
`timescale 1ns/1ps
module spi_master_device #(
   parameter int CLK_DIV    = 25,
   parameter int PRE_PULSES = 2
) (
   input  logic        CLK_50,
   input  logic        RESET,
   input  logic        START,
   input  logic [15:0] TX_DATA,
   output logic        BUSY,
   output logic        DONE,
   output logic [15:0] RX_DATA,
   output logic        SCK,
   output logic        MOSI,
   output logic        CSbar,
   input  logic        MISO
);

   typedef enum logic [2:0] {IDLE, PRE, CS_SETUP, XFER, CS_HOLD, FINISH} state_t;

   localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
   localparam logic [5:0] PRE_LAST  = 6'(2 * PRE_PULSES - 1);
   localparam logic [5:0] XFER_LAST = 6'd33;
   localparam logic [5:0] LAST_FALL = 6'd32;

   state_t      state;
   logic [7:0]  div;
   logic [5:0]  half_cnt;
   logic [15:0] tx_shift;
   logic [15:0] rx_shift;
   logic        tick;

   assign tick = (div == DIV_LAST);

   // Every SCK/MOSI/CSbar change happens on a half-period tick; half_cnt counts
   // ticks inside PRE and XFER so each phase knows when it is finished.
   always_ff @(posedge CLK_50) begin
      if (RESET) begin
         state    <= IDLE;
         div      <= 8'd0;
         half_cnt <= 6'd0;
         tx_shift <= 16'h0000;
         rx_shift <= 16'h0000;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         RX_DATA  <= 16'h0000;
         SCK      <= 1'b0;
         MOSI     <= 1'b0;
         CSbar    <= 1'b1;
      end else begin
         DONE <= 1'b0;
         if (state != IDLE && state != FINISH) begin
            div <= tick ? 8'd0 : div + 8'd1;
         end
         case (state)
            IDLE: begin
               if (START) begin
                  tx_shift <= TX_DATA;
                  rx_shift <= 16'h0000;
                  div      <= 8'd0;
                  half_cnt <= 6'd0;
                  BUSY     <= 1'b1;
                  state    <= PRE;
               end
            end
            PRE: begin
               if (tick) begin
                  SCK <= ~SCK;
                  if (half_cnt == PRE_LAST) begin
                     half_cnt <= 6'd0;
                     CSbar    <= 1'b0;
                     MOSI     <= 1'b0;
                     state    <= CS_SETUP;
                  end else begin
                     half_cnt <= half_cnt + 6'd1;
                  end
               end
            end
            CS_SETUP: begin
               if (tick) begin
                  state <= XFER;
               end
            end
            XFER: begin
               // Odd half_cnt values are falling edges; falls 1..16 sample MISO
               // and present the next data bit, fall 17 only closes the frame.
               if (tick) begin
                  SCK      <= ~SCK;
                  half_cnt <= half_cnt + 6'd1;
                  if (SCK && half_cnt < LAST_FALL) begin
                     rx_shift <= {rx_shift[14:0], MISO};
                     MOSI     <= tx_shift[15];
                     tx_shift <= {tx_shift[14:0], 1'b0};
                  end
                  if (half_cnt == XFER_LAST) begin
                     state <= CS_HOLD;
                  end
               end
            end
            CS_HOLD: begin
               if (tick) begin
                  CSbar   <= 1'b1;
                  MOSI    <= 1'b0;
                  DONE    <= 1'b1;
                  RX_DATA <= rx_shift;
                  state   <= FINISH;
               end
            end
            FINISH: begin
               BUSY  <= 1'b0;
               div   <= 8'd0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_device.sv
// Directed bench for spi_master_device: a table of frames against a behavioural
// slave, plus sequences for START during a frame, held START, mid-frame reset and a fast divider.
`timescale 1ns/1ps
module tb_spi_master_device;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, start2;
   logic [15:0] tx_data, tx2;
   logic        busy, done, sck, mosi, csbar;
   logic [15:0] rx_data;
   logic        busy2, done2, sck2, mosi2, csbar2;
   logic [15:0] rx2;
   logic        miso = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   spi_master_device dut (
      .CLK_50(clk), .RESET(reset), .START(start), .TX_DATA(tx_data),
      .BUSY(busy), .DONE(done), .RX_DATA(rx_data),
      .SCK(sck), .MOSI(mosi), .CSbar(csbar), .MISO(miso)
   );

   spi_master_device #(.CLK_DIV(2), .PRE_PULSES(1)) dut_fast (
      .CLK_50(clk), .RESET(reset), .START(start2), .TX_DATA(tx2),
      .BUSY(busy2), .DONE(done2), .RX_DATA(rx2),
      .SCK(sck2), .MOSI(mosi2), .CSbar(csbar2), .MISO(1'b1)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc++;

   // Behavioural slave: counts rises, captures MOSI on rises 2..17 and
   // presents its word MSB first on rises 1..16.
   logic [15:0] slave_word = 16'h0000;
   logic [15:0] slave_cap = 16'h0000;
   int pre_rises = 0;
   int xfer_rises = 0;

   always @(negedge csbar) begin
      xfer_rises = 0;
      slave_cap  = 16'h0000;
   end

   always @(posedge sck) begin
      if (csbar) pre_rises++;
      else begin
         xfer_rises++;
         if (xfer_rises >= 2) slave_cap = {slave_cap[14:0], mosi};
         if (xfer_rises <= 16) miso = slave_word[4'(16 - xfer_rises)];
      end
   end

   logic [15:0] cap2 = 16'h0000;
   int pre2 = 0;
   int xr2 = 0;

   always @(negedge csbar2) begin
      xr2  = 0;
      cap2 = 16'h0000;
   end

   always @(posedge sck2) begin
      if (csbar2) pre2++;
      else begin
         xr2++;
         if (xr2 >= 2) cap2 = {cap2[14:0], mosi2};
      end
   end

   int  done_count = 0;
   int  busy_gap = 0;
   logic monitor_busy = 1'b0;

   always @(negedge clk) begin
      if (done) done_count++;
      if (monitor_busy && !busy) busy_gap++;
   end

   typedef struct {
      logic [15:0] tx;
      logic [15:0] slave;
      logic [15:0] exp_rx;
      logic [15:0] exp_cap;
   } vec_t;

   vec_t vecs[5];

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic wait_done(input int t0, output int latency);
      while (!done && (cyc - t0) < 3000) begin
         @(posedge clk);
         #1;
      end
      latency = cyc - t0;
   endtask

   task automatic apply_stimulus(input logic [15:0] tx, input logic [15:0] word, output int latency);
      int t0;
      slave_word = word;
      pre_rises  = 0;
      tx_data    = tx;
      start      = 1'b1;
      @(posedge clk);
      #1;
      t0    = cyc;
      start = 1'b0;
      wait_done(t0, latency);
   endtask

   initial begin
      int lat;
      int t0;
      int d0;
      int n;

      vecs[0] = '{tx: 16'hA5C3, slave: 16'h1234, exp_rx: 16'h1234, exp_cap: 16'hA5C3};
      vecs[1] = '{tx: 16'h0000, slave: 16'hFFFF, exp_rx: 16'hFFFF, exp_cap: 16'h0000};
      vecs[2] = '{tx: 16'hFFFF, slave: 16'h0000, exp_rx: 16'h0000, exp_cap: 16'hFFFF};
      vecs[3] = '{tx: 16'h8001, slave: 16'h7FFE, exp_rx: 16'h7FFE, exp_cap: 16'h8001};
      vecs[4] = '{tx: 16'h3C5A, slave: 16'hC3A5, exp_rx: 16'hC3A5, exp_cap: 16'h3C5A};

      reset = 1'b1; start = 1'b0; start2 = 1'b0; tx_data = 16'h0; tx2 = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_sck", sck, 0);
      check_output("reset_csbar", csbar, 1);
      check_output("reset_mosi", mosi, 0);
      check_output("reset_busy", busy, 0);
      check_output("reset_done", done, 0);
      check_output("reset_rx", rx_data, 16'h0000);
      check_output("reset_csbar_fast", csbar2, 1);
      check_output("reset_busy_fast", busy2, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 5; i++) begin
         apply_stimulus(vecs[i].tx, vecs[i].slave, lat);
         check_output($sformatf("latency_%0d", i), lat, 1000);
         check_output($sformatf("rx_%0d", i), rx_data, vecs[i].exp_rx);
         check_output($sformatf("slave_cap_%0d", i), slave_cap, vecs[i].exp_cap);
         check_output($sformatf("pre_rises_%0d", i), pre_rises, 2);
         check_output($sformatf("xfer_rises_%0d", i), xfer_rises, 17);
         check_output($sformatf("busy_at_done_%0d", i), busy, 1);
         check_output($sformatf("csbar_at_done_%0d", i), csbar, 1);
         @(posedge clk);
         #1;
         check_output($sformatf("done_pulse_%0d", i), done, 0);
         check_output($sformatf("busy_after_%0d", i), busy, 0);
      end

      // START pulsed in the middle of a frame, with TX_DATA changed as well
      d0 = done_count;
      busy_gap = 0;
      slave_word = 16'h5A5A;
      tx_data = 16'h1357;
      start = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      start = 1'b0;
      monitor_busy = 1'b1;
      repeat (299) @(posedge clk);
      #1;
      tx_data = 16'hFFFF;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(t0, lat);
      monitor_busy = 1'b0;
      check_output("midstart_latency", lat, 1000);
      check_output("midstart_rx", rx_data, 16'h5A5A);
      check_output("midstart_cap", slave_cap, 16'h1357);
      check_output("midstart_busy_gap", busy_gap, 0);
      repeat (50) @(posedge clk);
      #1;
      check_output("midstart_done_count", done_count - d0, 1);
      check_output("midstart_idle_busy", busy, 0);

      // START held high across two frames
      slave_word = 16'h0F0F;
      tx_data = 16'hFFFF;
      start = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      wait_done(t0, lat);
      check_output("held1_latency", lat, 1000);
      check_output("held1_cap", slave_cap, 16'hFFFF);
      check_output("held1_rx", rx_data, 16'h0F0F);
      tx_data = 16'h0001;
      @(posedge clk);
      #1;
      check_output("held_idle_busy", busy, 0);
      @(posedge clk);
      #1;
      t0 = cyc;
      check_output("held2_accept_busy", busy, 1);
      start = 1'b0;
      wait_done(t0, lat);
      check_output("held2_latency", lat, 1000);
      check_output("held2_cap", slave_cap, 16'h0001);
      check_output("held2_rx", rx_data, 16'h0F0F);
      repeat (4) @(posedge clk);
      #1;

      // Reset at the 8th transfer rising edge
      slave_word = 16'hFFFF;
      tx_data = 16'hAAAA;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      d0 = done_count;
      n = 0;
      while (!(xfer_rises == 8 && sck && !csbar) && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_output("abort_reached_rise8", xfer_rises, 8);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_output("abort_csbar", csbar, 1);
      check_output("abort_sck", sck, 0);
      check_output("abort_busy", busy, 0);
      check_output("abort_mosi", mosi, 0);
      check_output("abort_rx", rx_data, 16'h0000);
      repeat (1200) @(posedge clk);
      #1;
      check_output("abort_no_done", done_count - d0, 0);
      apply_stimulus(16'h1E0F, 16'h4321, lat);
      check_output("post_abort_latency", lat, 1000);
      check_output("post_abort_rx", rx_data, 16'h4321);
      check_output("post_abort_cap", slave_cap, 16'h1E0F);

      // Minimum divider, single load pulse, MISO tied high
      tx2 = 16'h8001;
      start2 = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      start2 = 1'b0;
      while (!done2 && (cyc - t0) < 500) begin
         @(posedge clk);
         #1;
      end
      check_output("fast_latency", cyc - t0, 76);
      check_output("fast_rx", rx2, 16'hFFFF);
      check_output("fast_cap", cap2, 16'h8001);
      check_output("fast_pre_rises", pre2, 1);
      check_output("fast_xfer_rises", xr2, 17);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
